// File: rtl/add_sub_serial.sv
// ---------------------------------------------------------------------------
// add_sub_serial
//   Digit-serial adder/subtractor. Operands are captured in IDLE, then
//   WIDTH/DIGIT ADD cycles each add one DIGIT-bit slice, LSB slice first. The
//   result is held in DONE until the consumer takes it.
//   Subtraction is A + ~B + 1: B is inverted at capture and the carry starts
//   at 1.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of DIGIT
//   DIGIT  bits processed per ADD cycle (1..WIDTH)
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   a/b/sub are valid
//   in_ready   operands can be accepted (IDLE only)
//   a, b       operands
//   sub        0: a+b, 1: a-b
//   out        result, valid while out_valid is high
//   carry_out  add: carry out of MSB; sub: 1 means no borrow (a >= b)
//   overflow   signed two's-complement overflow
//   out_valid  result available
//   out_ready  consumer takes the result
//   busy       operation in progress or result pending (ADD or DONE)
// ---------------------------------------------------------------------------
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic                carry;
  logic                sign_a;
  logic                sign_b;

  logic [WIDTH-1:0]       b_eff;
  logic [DIGIT:0]         digit_sum;
  logic [WIDTH+DIGIT-1:0] out_shift;
  logic                   last;

  // Operand B as it enters the adder: inverted for subtraction.
  assign b_eff = sub ? ~b : b;

  // One digit slice plus incoming carry; the top bit is the carry out.
  assign digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};

  // New sum digit enters at the MSB end; written as a concatenate-and-shift
  // so that DIGIT == WIDTH needs no special case.
  assign out_shift = {digit_sum[DIGIT-1:0], out} >> DIGIT;

  assign last     = (count == CW'(N - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state == ADD) || (state == DONE);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b_eff;
            carry  <= sub;
            count  <= '0;
            sign_a <= a[WIDTH-1];
            sign_b <= b_eff[WIDTH-1];
          end
        end
        ADD: begin
          out   <= out_shift[WIDTH-1:0];
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= digit_sum[DIGIT];
          count <= count + CW'(1);
          if (last) begin
            out_valid <= 1'b1;
            carry_out <= digit_sum[DIGIT];
            // On the last digit, digit_sum[DIGIT-1] is the result MSB.
            overflow  <= (sign_a == sign_b) && (digit_sum[DIGIT-1] != sign_a);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_add_sub_serial
//   Bench for add_sub_serial with three instances: WIDTH=8/DIGIT=1,
//   WIDTH=8/DIGIT=4 and WIDTH=16/DIGIT=4. Results are compared against an
//   arithmetic reference model. Inputs are driven and outputs sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_add_sub_serial;

  logic        clk;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  sb;
  logic [15:0] av [3];
  logic [15:0] bv [3];

  logic [2:0]  irdy;
  logic [2:0]  ovld;
  logic [2:0]  co;
  logic [2:0]  ovf;
  logic [2:0]  bsy;
  logic [7:0]  r0;
  logic [7:0]  r1;
  logic [15:0] r2;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .sub(sb[0]), .out(r0),
    .carry_out(co[0]), .overflow(ovf[0]), .out_valid(ovld[0]),
    .out_ready(ordy[0]), .busy(bsy[0])
  );

  add_sub_serial #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .sub(sb[1]), .out(r1),
    .carry_out(co[1]), .overflow(ovf[1]), .out_valid(ovld[1]),
    .out_ready(ordy[1]), .busy(bsy[1])
  );

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(av[2]), .b(bv[2]), .sub(sb[2]), .out(r2),
    .carry_out(co[2]), .overflow(ovf[2]), .out_valid(ovld[2]),
    .out_ready(ordy[2]), .busy(bsy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int cycles_of(int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [15:0] get_res(int i);
    if (i == 0)      return {8'h00, r0};
    else if (i == 1) return {8'h00, r1};
    else             return r2;
  endfunction

  // Reference: plain modular arithmetic on the true operand values.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic s, output logic [15:0] r,
                       output logic c, output logic v);
    longint m;
    longint ua;
    longint ub;
    longint full;
    logic   sa;
    logic   sbb;
    logic   sr;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (s) begin
      full = ua - ub;
      c    = (ua >= ub);
    end else begin
      full = ua + ub;
      c    = ((full >> w) & 1) != 0;
    end
    r   = 16'(full & m);
    sa  = a[w-1];
    sbb = b[w-1];
    sr  = r[w-1];
    v   = s ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
  endtask

  // Present operands for one cycle; returns at the falling edge after the
  // accepting edge, with the operand bus scrambled.
  task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic s);
    av[i] = a;
    bv[i] = b;
    sb[i] = s;
    iv[i] = 1'b1;
    @(negedge clk);
    iv[i] = 1'b0;
    av[i] = 16'($urandom);
    bv[i] = 16'($urandom);
    sb[i] = 1'($urandom);
  endtask

  // Cycles from the accepting edge until out_valid, bounded.
  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!ovld[i] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out(input int i);
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    sb   = '0;
    for (int i = 0; i < 3; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({irdy[i], ovld[i], co[i], ovf[i], bsy[i]} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_flags inst%0d: got rdy/vld/co/ov/busy=%b want 10000", i,
                 {irdy[i], ovld[i], co[i], ovf[i], bsy[i]});
      end
      n_checks++;
      if (get_res(i) !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_out inst%0d: got %h want 0000", i, get_res(i));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic        c;
    logic        v;
  } vec_t;

  task automatic test_directed;
    vec_t vecs [6];
    int   lat;
    vecs[0] = '{0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
    vecs[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0};
    vecs[3] = '{0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
    vecs[4] = '{1, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
    vecs[5] = '{2, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    foreach (vecs[k]) begin
      start_op(vecs[k].inst, vecs[k].a, vecs[k].b, vecs[k].s);
      wait_valid(vecs[k].inst, lat);
      n_checks++;
      if (lat !== cycles_of(vecs[k].inst)) begin
        n_fail++;
        $display("FAIL dir_latency vec%0d: got %0d want %0d", k, lat, cycles_of(vecs[k].inst));
      end
      n_checks++;
      if (get_res(vecs[k].inst) !== vecs[k].r) begin
        n_fail++;
        $display("FAIL dir_out vec%0d: got %h want %h", k, get_res(vecs[k].inst), vecs[k].r);
      end
      n_checks++;
      if ({co[vecs[k].inst], ovf[vecs[k].inst]} !== {vecs[k].c, vecs[k].v}) begin
        n_fail++;
        $display("FAIL dir_flags vec%0d: got co/ov=%b want %b", k,
                 {co[vecs[k].inst], ovf[vecs[k].inst]}, {vecs[k].c, vecs[k].v});
      end
      release_out(vecs[k].inst);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] er;
    logic        ec;
    logic        ev;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 30; n++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom);
        if (width_of(i) == 8) begin
          a[15:8] = '0;
          b[15:8] = '0;
        end
        model(width_of(i), a, b, s, er, ec, ev);
        start_op(i, a, b, s);
        wait_valid(i, lat);
        n_checks++;
        if (lat !== cycles_of(i)) begin
          n_fail++;
          $display("FAIL rand_latency inst%0d: got %0d want %0d", i, lat, cycles_of(i));
        end
        n_checks++;
        if ({get_res(i), co[i], ovf[i], bsy[i]} !== {er, ec, ev, 1'b1}) begin
          n_fail++;
          $display("FAIL rand_result inst%0d %h %s %h: got %h co=%b ov=%b busy=%b want %h co=%b ov=%b busy=1",
                   i, a, s ? "-" : "+", b, get_res(i), co[i], ovf[i], bsy[i], er, ec, ev);
        end
        release_out(i);
        n_checks++;
        if ({ovld[i], irdy[i]} !== 2'b01) begin
          n_fail++;
          $display("FAIL rand_release inst%0d: got vld/rdy=%b want 01", i, {ovld[i], irdy[i]});
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(0, 16'h005A, 16'h003C, 1'b0);
    wait_valid(0, lat);
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1;
      av[0] = 16'($urandom);
      bv[0] = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if ({r0, co[0], ovf[0], ovld[0], irdy[0], bsy[0]} !== {8'h96, 5'b01101}) begin
        n_fail++;
        $display("FAIL bp_hold cycle%0d: got out=%h co/ov/vld/rdy/busy=%b want 96 01101", k,
                 r0, {co[0], ovf[0], ovld[0], irdy[0], bsy[0]});
      end
    end
    iv[0] = 1'b0;
    release_out(0);
    n_checks++;
    if ({r0, ovld[0], irdy[0], bsy[0]} !== {8'h96, 3'b010}) begin
      n_fail++;
      $display("FAIL bp_release: got out=%h vld/rdy/busy=%b want 96 010", r0,
               {ovld[0], irdy[0], bsy[0]});
    end
    // out_ready with nothing pending must not disturb anything.
    ordy[0] = 1'b1;
    repeat (2) @(negedge clk);
    ordy[0] = 1'b0;
    n_checks++;
    if ({r0, ovld[0], irdy[0], bsy[0]} !== {8'h96, 3'b010}) begin
      n_fail++;
      $display("FAIL idle_out_ready: got out=%h vld/rdy/busy=%b want 96 010", r0,
               {ovld[0], irdy[0], bsy[0]});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(0, 16'h00C3, 16'h0011, 1'b1);
    wait_valid(0, lat);
    release_out(0);
    start_op(0, 16'h0001, 16'h0001, 1'b0);
    // First ADD shift has not happened yet: previous result still visible.
    n_checks++;
    if ({r0, irdy[0], bsy[0]} !== {8'hB2, 2'b01}) begin
      n_fail++;
      $display("FAIL b2b_hold: got out=%h rdy/busy=%b want b2 01", r0, {irdy[0], bsy[0]});
    end
    wait_valid(0, lat);
    n_checks++;
    if ({lat[7:0], r0, co[0], ovf[0]} !== {8'd8, 8'h02, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_result: got lat=%0d out=%h co/ov=%b want 8 02 00", lat, r0,
               {co[0], ovf[0]});
    end
    release_out(0);
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    start_op(0, 16'h00AA, 16'h0055, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({r0, co[0], ovf[0], ovld[0], irdy[0], bsy[0]} !== {8'h00, 5'b00010}) begin
      n_fail++;
      $display("FAIL rst_mid_state: got out=%h co/ov/vld/rdy/busy=%b want 00 00010", r0,
               {co[0], ovf[0], ovld[0], irdy[0], bsy[0]});
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ovld[0]) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_dropped: got %0d valid cycles want 0", seen);
    end
    start_op(0, 16'h0001, 16'h0001, 1'b0);
    wait_valid(0, lat);
    n_checks++;
    if ({lat[7:0], r0, co[0], ovf[0]} !== {8'd8, 8'h02, 2'b00}) begin
      n_fail++;
      $display("FAIL rst_mid_next_op: got lat=%0d out=%h co/ov=%b want 8 02 00", lat, r0,
               {co[0], ovf[0]});
    end
    release_out(0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
